// File: rtl/otter_csr_pkg.sv
// ----------------------------------------------------------------------------
// otter_csr_pkg
// Shared definitions for the OTTER machine-mode CSR file and interrupt
// controller: CSR addresses, mstatus bit positions and the offset at which
// interrupt channels appear in mie/mip/mcause.
// ----------------------------------------------------------------------------
package otter_csr_pkg;

    typedef logic [11:0] csr_addr_t;

    localparam csr_addr_t CSR_MSTATUS = 12'h300;
    localparam csr_addr_t CSR_MIE     = 12'h304;
    localparam csr_addr_t CSR_MTVEC   = 12'h305;
    localparam csr_addr_t CSR_MEPC    = 12'h341;
    localparam csr_addr_t CSR_MCAUSE  = 12'h342;
    localparam csr_addr_t CSR_MIP     = 12'h344;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;

    // Channel i is reported as cause 16+i and sits at bit 16+i of mie/mip.
    localparam int IRQ_CAUSE_BASE = 16;
    localparam int IRQ_FIELD_OFS  = 16;

    // Enough bits to name any of up to 16 channels.
    localparam int IRQ_ID_W       = 4;

endpackage

// File: rtl/irq_sync.sv
// ----------------------------------------------------------------------------
// irq_sync
// Brings one asynchronous interrupt line into the clock domain and detects
// its rising edge.
//   i_clk      system clock
//   i_rst      asynchronous active-high reset
//   i_d        raw interrupt line
//   o_q_level  synchronised level, delayed one flop past the chain
//   o_q_rise   one-cycle pulse on a synchronised rising edge,
//              time-aligned with o_q_level going high
// ----------------------------------------------------------------------------
module irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q_level,
    output logic o_q_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_rise;

    // Synchroniser chain, one extra flop holding the previous synchronised
    // value, and a registered edge pulse so that level and edge outputs
    // change on the same clock.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
        end
    end

    assign o_q_level = r_prev;
    assign o_q_rise  = r_rise;

endmodule

// File: rtl/otter_csr_intc.sv
// ----------------------------------------------------------------------------
// otter_csr_intc
// Machine-mode CSR file and multi-channel interrupt controller for the OTTER.
// Raw IRQ lines are synchronised, latched (edge channels) or followed (level
// channels), masked by mie and mstatus.MIE, and the lowest-numbered active
// channel is reported to the control unit through o_intr.
//   i_clk / i_rst        clock, asynchronous active-high reset
//   i_irq                raw interrupt requests, one per channel
//   i_pc                 PC of the instruction being interrupted
//   i_int_taken          trap entry pulse from the control unit
//   i_mret_exec          mret pulse from the control unit
//   i_csr_addr/we/wd     CSR access from the datapath
//   o_csr_rd             CSR read data (combinational on i_csr_addr)
//   o_intr               interrupt request to the control unit
//   o_mtvec / o_mepc     trap vector and return address to the PC mux
// ----------------------------------------------------------------------------
module otter_csr_intc
    import otter_csr_pkg::*;
#(
    parameter int                   XLEN        = 32,
    parameter int                   NUM_IRQ     = 4,
    parameter int                   SYNC_STAGES = 2,
    parameter logic [NUM_IRQ-1:0]   EDGE_MASK   = '1,
    parameter logic [XLEN-1:0]      MTVEC_RST   = '0
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NUM_IRQ-1:0]  i_irq,
    input  logic [XLEN-1:0]     i_pc,
    input  logic                i_int_taken,
    input  logic                i_mret_exec,
    input  csr_addr_t           i_csr_addr,
    input  logic                i_csr_we,
    input  logic [XLEN-1:0]     i_csr_wd,
    output logic [XLEN-1:0]     o_csr_rd,
    output logic                o_intr,
    output logic [XLEN-1:0]     o_mtvec,
    output logic [XLEN-1:0]     o_mepc
);

    // Only direct-mode vectors and word-aligned return addresses exist.
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] MTVEC_INIT = MTVEC_RST & ALIGN_MASK;

    logic                   r_mstatus_mie;
    logic                   r_mstatus_mpie;
    logic [NUM_IRQ-1:0]     r_mie_en;
    logic [NUM_IRQ-1:0]     r_pending;
    logic [XLEN-1:0]        r_mtvec;
    logic [XLEN-1:0]        r_mepc;
    logic [XLEN-1:0]        r_mcause;

    logic [NUM_IRQ-1:0]     w_level;
    logic [NUM_IRQ-1:0]     w_rise;
    logic [NUM_IRQ-1:0]     w_active;
    logic [NUM_IRQ-1:0]     w_pending_next;
    logic [IRQ_ID_W-1:0]    w_id;
    logic                   w_take_irq;
    logic [XLEN-1:0]        w_cause;
    logic                   w_wr_mstatus;
    logic                   w_wr_mie;
    logic                   w_wr_mtvec;
    logic                   w_wr_mepc;
    logic                   w_wr_mcause;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
        irq_sync #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_d       (i_irq[g]),
            .o_q_level (w_level[g]),
            .o_q_rise  (w_rise[g])
        );
    end

    // Priority encoder: scanning downwards lets the lowest active index
    // overwrite any higher one.
    always_comb begin
        w_active = r_pending & r_mie_en;
        w_id     = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_id = IRQ_ID_W'(i);
            end
        end
    end

    assign o_intr     = r_mstatus_mie & (|w_active);
    assign w_take_irq = i_int_taken & o_intr;
    assign w_cause    = {1'b1, (XLEN-1)'(IRQ_CAUSE_BASE) + (XLEN-1)'(w_id)};

    assign w_wr_mstatus = i_csr_we && (i_csr_addr == CSR_MSTATUS);
    assign w_wr_mie     = i_csr_we && (i_csr_addr == CSR_MIE);
    assign w_wr_mtvec   = i_csr_we && (i_csr_addr == CSR_MTVEC);
    assign w_wr_mepc    = i_csr_we && (i_csr_addr == CSR_MEPC);
    assign w_wr_mcause  = i_csr_we && (i_csr_addr == CSR_MCAUSE);

    // Next pending vector. Edge channels latch until serviced, and a new
    // edge arriving in the same cycle as the service keeps the bit set.
    // Level channels simply follow the synchronised line.
    always_comb begin
        w_pending_next = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (EDGE_MASK[i]) begin
                w_pending_next[i] = w_rise[i] |
                    (r_pending[i] & ~(w_take_irq && (int'(w_id) == i)));
            end else begin
                w_pending_next[i] = w_level[i];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_next;
        end
    end

    // mstatus: trap entry outranks mret, which outranks a software write.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
        end else if (i_int_taken) begin
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
        end else if (i_mret_exec) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
        end else if (w_wr_mstatus) begin
            r_mstatus_mie  <= i_csr_wd[MSTATUS_MIE];
            r_mstatus_mpie <= i_csr_wd[MSTATUS_MPIE];
        end
    end

    // Remaining CSRs. mepc is captured on every trap entry, but mcause only
    // when a real interrupt was being requested; otherwise a software write
    // to mcause in that cycle still lands.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mie_en <= '0;
            r_mtvec  <= MTVEC_INIT;
            r_mepc   <= '0;
            r_mcause <= '0;
        end else begin
            if (w_wr_mie) begin
                r_mie_en <= i_csr_wd[IRQ_FIELD_OFS +: NUM_IRQ];
            end
            if (w_wr_mtvec) begin
                r_mtvec <= i_csr_wd & ALIGN_MASK;
            end
            if (i_int_taken) begin
                r_mepc <= i_pc & ALIGN_MASK;
            end else if (w_wr_mepc) begin
                r_mepc <= i_csr_wd & ALIGN_MASK;
            end
            if (w_take_irq) begin
                r_mcause <= w_cause;
            end else if (w_wr_mcause) begin
                r_mcause <= i_csr_wd;
            end
        end
    end

    // Read mux shows stored values only; a write in flight is not bypassed.
    always_comb begin
        o_csr_rd = '0;
        case (i_csr_addr)
            CSR_MSTATUS: begin
                o_csr_rd[MSTATUS_MIE]  = r_mstatus_mie;
                o_csr_rd[MSTATUS_MPIE] = r_mstatus_mpie;
            end
            CSR_MIE:     o_csr_rd[IRQ_FIELD_OFS +: NUM_IRQ] = r_mie_en;
            CSR_MTVEC:   o_csr_rd = r_mtvec;
            CSR_MEPC:    o_csr_rd = r_mepc;
            CSR_MCAUSE:  o_csr_rd = r_mcause;
            CSR_MIP:     o_csr_rd[IRQ_FIELD_OFS +: NUM_IRQ] = r_pending;
            default:     o_csr_rd = '0;
        endcase
    end

    assign o_mtvec = r_mtvec;
    assign o_mepc  = r_mepc;

endmodule
